// File: rtl/addsub_if.sv
// Operand/result bundle for the multi-cycle adder/subtractor addsub_seq.
// The master side issues requests; the slave side (the datapath) returns results and flags.
interface addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output start, op_sub, a, b, c_in,
        input  busy, done, result, c_out, overflow, zero, negative
    );

    modport slave (
        input  start, op_sub, a, b, c_in,
        output busy, done, result, c_out, overflow, zero, negative
    );
endinterface

// File: rtl/addsub_seq.sv
// Chunked multi-cycle WIDTH-bit adder/subtractor with start/busy/done handshake and C/V/Z/N flags.
// Optional ADDSUB_SATURATE_EN: clamp the result to signed max/min on signed overflow.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic     clk,
    input logic     rst,
    addsub_if.slave bus
);
    localparam int NSTEP  = WIDTH / CHUNK;
    localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_r;
    logic [STEP_W-1:0] step_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              carry_r;
    logic              op_sub_r;
    logic [WIDTH-1:0]  acc_r;
    logic              busy_r;
    logic              done_r;
    logic [WIDTH-1:0]  result_r;
    logic              c_out_r;
    logic              overflow_r;
    logic              zero_r;
    logic              negative_r;

    logic [CHUNK-1:0]  a_chunk_s;
    logic [CHUNK-1:0]  b_chunk_s;
    logic [CHUNK:0]    chunk_s;
    logic [WIDTH-1:0]  full_s;
    logic [WIDTH-1:0]  final_s;
    logic              c_fin_s;
    logic              c_msb_s;
    logic              ovf_s;

    function automatic logic [CHUNK:0] chunk_add(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             cin
    );
        chunk_add = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    endfunction

    // Current chunk sum plus the would-be final result and its signed-overflow status.
    always_comb begin
        a_chunk_s = a_r[int'(step_r) * CHUNK +: CHUNK];
        b_chunk_s = b_r[int'(step_r) * CHUNK +: CHUNK];
        chunk_s   = chunk_add(a_chunk_s, b_chunk_s, carry_r);
        full_s    = acc_r;
        full_s[int'(step_r) * CHUNK +: CHUNK] = chunk_s[CHUNK-1:0];
        c_fin_s   = chunk_s[CHUNK];
        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
        c_msb_s   = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ full_s[WIDTH-1];
        ovf_s     = c_msb_s ^ c_fin_s;
`ifdef ADDSUB_SATURATE_EN
        // On overflow the operand A sign equals the sign of the true result.
        if (ovf_s) begin
            final_s = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            final_s = full_s;
        end
`else
        final_s = full_s;
`endif
    end

    // Control FSM, operand latch, chunk accumulator and registered result/flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            step_r     <= {STEP_W{1'b0}};
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            op_sub_r   <= 1'b0;
            acc_r      <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
            c_out_r    <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
            negative_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_r      <= bus.a;
                        b_r      <= bus.op_sub ? ~bus.b : bus.b;
                        carry_r  <= bus.op_sub ? ~bus.c_in : bus.c_in;
                        op_sub_r <= bus.op_sub;
                        step_r   <= {STEP_W{1'b0}};
                        state_r  <= BUSY;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                    end
                end
                BUSY: begin
                    acc_r[int'(step_r) * CHUNK +: CHUNK] <= chunk_s[CHUNK-1:0];
                    carry_r <= chunk_s[CHUNK];
                    if (step_r == LAST_STEP) begin
                        state_r    <= DONE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        result_r   <= final_s;
                        // Subtraction reports borrow, the inverse of the adder carry.
                        c_out_r    <= op_sub_r ^ c_fin_s;
                        overflow_r <= ovf_s;
                        zero_r     <= (final_s == {WIDTH{1'b0}});
                        negative_r <= final_s[WIDTH-1];
                    end else begin
                        step_r     <= step_r + STEP_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.result   = result_r;
    assign bus.c_out    = c_out_r;
    assign bus.overflow = overflow_r;
    assign bus.zero     = zero_r;
    assign bus.negative = negative_r;
endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq (WIDTH=16, CHUNK=4): vector table, scoreboard queue, corner sequences.
module tb_addsub_seq;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NSTEP = 4;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
        int          cyc;
        string       name;
    } exp_t;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    addsub_if #(.WIDTH(WIDTH)) bus();

    addsub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] res, input logic c, input logic v,
                                input logic z, input logic n, input string name);
        exp_t e;
        e.res = res; e.c = c; e.v = v; e.z = z; e.n = n; e.cyc = 0; e.name = name;
        return e;
    endfunction

    // Reference using plain 17-bit arithmetic and operand-sign overflow rules.
    function automatic exp_t model(input logic op, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input string name);
        logic [16:0] full;
        exp_t e;
        if (op) full = {1'b0, a} - {1'b0, b} - {16'd0, cin};
        else    full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        e.res = full[15:0];
        e.c   = full[16];
        e.v   = op ? ((a[15] != b[15]) && (full[15] != a[15]))
                   : ((a[15] == b[15]) && (full[15] != a[15]));
`ifdef ADDSUB_SATURATE_EN
        if (e.v) e.res = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        e.z = (e.res == 16'h0000);
        e.n = e.res[15];
        e.cyc = 0;
        e.name = name;
        return e;
    endfunction

    // Scoreboard: every done pulse pops and checks the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_result"}, bus.result, e.res);
                chk({e.name, "_c_out"}, bus.c_out, e.c);
                chk({e.name, "_overflow"}, bus.overflow, e.v);
                chk({e.name, "_zero"}, bus.zero, e.z);
                chk({e.name, "_negative"}, bus.negative, e.n);
                chk({e.name, "_busy_at_done"}, bus.busy, 1'b0);
                chk({e.name, "_latency"}, cyc, e.cyc);
            end
        end
    end

    // Waits (bounded) for busy low, then issues one request; returns #1 after the accepting edge.
    task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input exp_t e);
        int n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: busy still %b after %0d cycles, expected 0", e.name, bus.busy, n);
        end
        bus.op_sub = op;
        bus.a      = a;
        bus.b      = b;
        bus.c_in   = cin;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        e.cyc = cyc + NSTEP;
        exp_q.push_back(e);
        chk({e.name, "_busy_after_accept"}, bus.busy, 1'b1);
        bus.start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: %0d results pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        exp_t e;
        exp_t e_lo;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rop;
        logic        rcin;

        // op, a, b, c_in, result, C, V, Z, N
`ifdef ADDSUB_SATURATE_EN
        vecs[0] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        vecs[0] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
        vecs[3] = '{1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};

        bus.start = 1'b0; bus.op_sub = 1'b0; bus.a = 16'h0000; bus.b = 16'h0000; bus.c_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_done", bus.done, 1'b0);
        chk("reset_result", bus.result, 16'h0000);
        chk("reset_flags", {bus.c_out, bus.overflow, bus.zero, bus.negative}, 4'b0000);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            e = mk(vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n, $sformatf("vec%0d", i));
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, e);
            wait_drain($sformatf("vec%0d", i));
        end

        // Result is held after done while idle.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_result", bus.result, 16'h0001);
        chk("hold_done_low", bus.done, 1'b0);

        // Back-to-back random operations (each start lands in the previous done cycle).
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rop = 1'($urandom_range(0, 1)); rcin = 1'($urandom_range(0, 1));
            run_op(rop, ra, rb, rcin, model(rop, ra, rb, rcin, $sformatf("rand%0d", i)));
        end
        wait_drain("rand");

        // start pulses while busy are ignored; start held in the done cycle is accepted.
        run_op(1'b0, 16'h0102, 16'h0304, 1'b0, mk(16'h0406, 1'b0, 1'b0, 1'b0, 1'b0, "c4_first"));
        bus.op_sub = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.c_in = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("c4_done_pulse", bus.done, 1'b1);
        bus.op_sub = 1'b0; bus.a = 16'h0010; bus.b = 16'h0020; bus.c_in = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        e = mk(16'h0031, 1'b0, 1'b0, 1'b0, 1'b0, "c4_second");
        e.cyc = cyc + NSTEP;
        exp_q.push_back(e);
        chk("c4_second_busy", bus.busy, 1'b1);
        chk("c4_done_one_cycle", bus.done, 1'b0);
        bus.start = 1'b0;
        wait_drain("c4");

        // Reset in the middle of an operation aborts it with no done pulse.
        run_op(1'b0, 16'h1111, 16'h2222, 1'b0, mk(16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, "pre_abort"));
        wait_drain("pre_abort");
        run_op(1'b1, 16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, "aborted"));
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_result", bus.result, 16'h0000);
        chk("abort_flags", {bus.c_out, bus.overflow, bus.zero, bus.negative}, 4'b0000);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_stays_idle", bus.busy, 1'b0);

        // Chained 32-bit subtract 0x00010000 - 0x00000001 via borrow.
        e_lo = mk(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, "chain_lo");
        run_op(1'b1, 16'h0000, 16'h0001, 1'b0, e_lo);
        wait_drain("chain_lo");
        run_op(1'b1, 16'h0001, 16'h0000, e_lo.c, mk(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, "chain_hi"));
        wait_drain("chain_hi");

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
